gb_cpu_fetch_unit: RTL and testbench



---
 rtl/gb_cpu_fetch_unit_if.sv | 27 ++
 rtl/gb_cpu_fetch_unit.sv | 117 +++++++++++
 tb/tb_gb_cpu_fetch_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gb_cpu_fetch_unit_if.sv
// Fetch-unit bus: memory read port, sequencer controls and decoder outputs.
// master = fetch unit side, slave = memory/sequencer/decoder side.
interface gb_cpu_fetch_unit_if;
    logic [7:0]  data_in;
    logic        instr_done;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        halt_bug;
    logic [15:0] addr;
    logic        mem_rd;
    logic [15:0] pc;
    logic [1:0]  t_cycle;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic        opcode_valid;

    modport master (
        input  data_in, instr_done, pc_inc, pc_load, pc_load_val, halt_bug,
        output addr, mem_rd, pc, t_cycle, opcode, cb_prefix, opcode_valid
    );

    modport slave (
        output data_in, instr_done, pc_inc, pc_load, pc_load_val, halt_bug,
        input  addr, mem_rd, pc, t_cycle, opcode, cb_prefix, opcode_valid
    );
endinterface

// File: rtl/gb_cpu_fetch_unit.sv
// Game Boy CPU fetch stage: PC, T/M-cycle timebase, 0xCB prefix resolution.
// Optional HALT-bug PC suppression enabled by defining GB_CPU_HALT_BUG_EN.
module gb_cpu_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic                 clk,
    input logic                 reset,
    gb_cpu_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        CB_FETCH = 2'd1,
        EXEC     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  t_q;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  op_q, op_d;
    logic        cb_q, cb_d;
    logic        vld_q, vld_d;
    logic        boundary;

`ifdef GB_CPU_HALT_BUG_EN
    logic        hb_q, hb_d;
`endif

    assign boundary = (t_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            t_q     <= 2'd0;
            pc_q    <= RESET_PC;
            op_q    <= 8'h00;
            cb_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_q + 2'd1;
            pc_q    <= pc_d;
            op_q    <= op_d;
            cb_q    <= cb_d;
            vld_q   <= vld_d;
        end
    end

`ifdef GB_CPU_HALT_BUG_EN
    always_ff @(posedge clk) begin
        if (reset) hb_q <= 1'b0;
        else       hb_q <= hb_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        cb_d    = cb_q;
        vld_d   = 1'b0;
`ifdef GB_CPU_HALT_BUG_EN
        hb_d    = hb_q;
`endif
        if (boundary) begin
            case (state_q)
                FETCH: begin
`ifdef GB_CPU_HALT_BUG_EN
                    // Armed HALT bug: refetch the same byte once.
                    if (!hb_q) pc_d = pc_q + 16'd1;
                    hb_d = 1'b0;
`else
                    pc_d = pc_q + 16'd1;
`endif
                    if (bus.data_in == 8'hCB) begin
                        state_d = CB_FETCH;
                    end else begin
                        op_d    = bus.data_in;
                        cb_d    = 1'b0;
                        vld_d   = 1'b1;
                        state_d = EXEC;
                    end
                end
                CB_FETCH: begin
                    pc_d    = pc_q + 16'd1;
                    op_d    = bus.data_in;
                    cb_d    = 1'b1;
                    vld_d   = 1'b1;
                    state_d = EXEC;
                end
                EXEC: begin
                    if (bus.pc_load)     pc_d = bus.pc_load_val;
                    else if (bus.pc_inc) pc_d = pc_q + 16'd1;
`ifdef GB_CPU_HALT_BUG_EN
                    if (bus.halt_bug) hb_d = 1'b1;
`endif
                    if (bus.instr_done) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign bus.addr         = pc_q;
    assign bus.mem_rd       = (state_q != EXEC);
    assign bus.pc           = pc_q;
    assign bus.t_cycle      = t_q;
    assign bus.opcode       = op_q;
    assign bus.cb_prefix    = cb_q;
    assign bus.opcode_valid = vld_q;

`ifndef GB_CPU_HALT_BUG_EN
    logic unused_hb;
    assign unused_hb = bus.halt_bug;
`endif

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Directed testbench for gb_cpu_fetch_unit with a flat 64 KiB memory model.
// Expectations follow GB_CPU_HALT_BUG_EN when defined for the build.
module tb_gb_cpu_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] mem [0:65535];

    gb_cpu_fetch_unit_if bus ();

    gb_cpu_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.data_in = mem[bus.addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.instr_done  = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_load_val = 16'h0000;
        bus.halt_bug    = 1'b0;
        clr_mem();
        tick(2);

        mem[0] = 8'h80;
        bus.instr_done = 1'b1;
        do_reset();
        chk("rst_pc", bus.pc, 16'h0000);
        chk("rst_t", bus.t_cycle, 2'd0);
        chk("rst_memrd", bus.mem_rd, 1'b1);
        chk("rst_addr", bus.addr, 16'h0000);
        chk("rst_op", bus.opcode, 8'h00);
        chk("rst_cb", bus.cb_prefix, 1'b0);
        chk("rst_vld", bus.opcode_valid, 1'b0);
        tick(3);
        chk("c3_vld", bus.opcode_valid, 1'b0);
        chk("c3_t", bus.t_cycle, 2'd3);
        tick(1);
        chk("c4_vld", bus.opcode_valid, 1'b1);
        chk("c4_op", bus.opcode, 8'h80);
        chk("c4_cb", bus.cb_prefix, 1'b0);
        chk("c4_pc", bus.pc, 16'h0001);
        chk("c4_memrd", bus.mem_rd, 1'b0);
        tick(1);
        chk("c5_vld", bus.opcode_valid, 1'b0);
        chk("c5_op_hold", bus.opcode, 8'h80);
        tick(3);
        chk("c8_memrd", bus.mem_rd, 1'b1);
        chk("c8_addr", bus.addr, 16'h0001);

        clr_mem();
        mem[0] = 8'hCB;
        mem[1] = 8'h37;
        bus.instr_done = 1'b0;
        do_reset();
        tick(4);
        chk("cb_c4_vld", bus.opcode_valid, 1'b0);
        chk("cb_c4_memrd", bus.mem_rd, 1'b1);
        chk("cb_c4_pc", bus.pc, 16'h0001);
        tick(4);
        chk("cb_c8_vld", bus.opcode_valid, 1'b1);
        chk("cb_c8_op", bus.opcode, 8'h37);
        chk("cb_c8_cb", bus.cb_prefix, 1'b1);
        chk("cb_c8_pc", bus.pc, 16'h0002);

        mem[1] = 8'hCB;
        do_reset();
        tick(8);
        chk("cbcb_vld", bus.opcode_valid, 1'b1);
        chk("cbcb_op", bus.opcode, 8'hCB);
        chk("cbcb_cb", bus.cb_prefix, 1'b1);
        chk("cbcb_memrd", bus.mem_rd, 1'b0);
        bus.pc_load     = 1'b1;
        bus.pc_load_val = 16'hFFFF;
        bus.pc_inc      = 1'b1;
        bus.instr_done  = 1'b1;
        tick(3);
        chk("ld_hold_pc", bus.pc, 16'h0002);
        tick(1);
        chk("ld_addr", bus.addr, 16'hFFFF);
        chk("ld_memrd", bus.mem_rd, 1'b1);
        bus.pc_load = 1'b0;
        bus.pc_inc  = 1'b0;
        tick(4);
        chk("wrap_pc", bus.pc, 16'h0000);
        chk("wrap_vld", bus.opcode_valid, 1'b1);
        chk("wrap_cb", bus.cb_prefix, 1'b0);

        clr_mem();
        mem[0] = 8'hCB;
        mem[1] = 8'h37;
        mem[2] = 8'hCB;
        mem[3] = 8'h11;
        bus.instr_done = 1'b1;
        do_reset();
        tick(18);
        chk("mid_t", bus.t_cycle, 2'd2);
        chk("mid_pc", bus.pc, 16'h0003);
        chk("mid_cb", bus.cb_prefix, 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mrst_t", bus.t_cycle, 2'd0);
        chk("mrst_pc", bus.pc, 16'h0000);
        chk("mrst_memrd", bus.mem_rd, 1'b1);
        chk("mrst_cb", bus.cb_prefix, 1'b0);

        clr_mem();
        mem[0] = 8'h76;
        bus.instr_done = 1'b1;
        do_reset();
        tick(4);
        bus.pc_load     = 1'b1;
        bus.pc_load_val = 16'h0150;
        bus.halt_bug    = 1'b1;
        tick(4);
        bus.pc_load  = 1'b0;
        bus.halt_bug = 1'b0;
        chk("hb_f1_addr", bus.addr, 16'h0150);
        chk("hb_f1_memrd", bus.mem_rd, 1'b1);
        tick(8);
        chk("hb_f2_memrd", bus.mem_rd, 1'b1);
`ifdef GB_CPU_HALT_BUG_EN
        chk("hb_f2_addr", bus.addr, 16'h0150);
        tick(4);
        chk("hb_after_pc", bus.pc, 16'h0151);
`else
        chk("hb_f2_addr", bus.addr, 16'h0151);
        tick(4);
        chk("hb_after_pc", bus.pc, 16'h0152);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(posedge clk) begin
        if (checks > 1000) begin
            $display("FAIL timeout: got %0d checks expected under 1000",
                     checks);
            $fatal(1);
        end
    end

endmodule
